byte_encode: RTL and testbench



---
 rtl/kyber_pkg.sv | 29 ++
 rtl/byte_encode_bit_packer.sv | 77 +++++++
 rtl/byte_encode.sv | 117 +++++++++++
 tb/tb_byte_encode.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared constants, state encoding and helpers for the Kyber polynomial
// serializer blocks.
package kyber_pkg;

    localparam int KYBER_N       = 256;
    localparam int KYBER_COEFF_W = 12;
    localparam int KYBER_WORD_W  = 64;
    localparam int KYBER_L_MAX   = 12;
    localparam int KYBER_LANES   = 4;

    // Accumulator width: up to 63 leftover bits plus one 48-bit beat.
    localparam int KYBER_ACC_W   = 112;
    localparam int KYBER_CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } encode_state_t;

    // Out-of-range encode widths (0, 13..15) fall back to the widest legal l.
    function automatic logic [3:0] clamp_l(input logic [3:0] l);
        if (l == 4'd0 || l > 4'(KYBER_L_MAX)) begin
            return 4'(KYBER_L_MAX);
        end
        return l;
    endfunction

endpackage

// File: rtl/byte_encode_bit_packer.sv
// Lane compaction plus bit accumulator: squeezes 4 coefficients of l bits
// into 4l contiguous bits, appends them to the accumulator and retires
// 64-bit words from the bottom.
module bit_packer
    import kyber_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clr,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [3:0]                i_l,
    input  logic [KYBER_LANES*KYBER_COEFF_W-1:0] i_coeffs,
    output logic [KYBER_WORD_W-1:0]   o_word,
    output logic [KYBER_CNT_W-1:0]    o_cnt
);

    localparam int BEAT_W = KYBER_LANES * KYBER_COEFF_W;

    logic [KYBER_ACC_W-1:0] acc_q, acc_d;
    logic [KYBER_CNT_W-1:0] cnt_q, cnt_d;

    logic [KYBER_COEFF_W-1:0] mask;
    logic [BEAT_W-1:0]        packed_bits;
    logic [5:0]               beat_bits;
    logic [KYBER_ACC_W-1:0]   acc_base;
    logic [KYBER_CNT_W-1:0]   push_off;

    // Compact the four lanes: lane m lands at bit offset m*l, high bits masked off.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop, so no path leaves it unassigned and no latch is inferred.
        mask        = 12'((13'd1 << i_l) - 13'd1);
        packed_bits = '0;
        for (int m = 0; m < KYBER_LANES; m++) begin
            packed_bits = packed_bits
                        | (BEAT_W'(i_coeffs[KYBER_COEFF_W*m +: KYBER_COEFF_W] & mask) << (m * int'(i_l)));
        end
        beat_bits = {i_l, 2'b00};
    end

    // Next accumulator/count: a pop shifts first, so a same-cycle push lands 64 lower.
    always_comb begin
        acc_base = i_pop ? (acc_q >> KYBER_WORD_W) : acc_q;
        push_off = i_pop ? (cnt_q - 7'(KYBER_WORD_W)) : cnt_q;
        acc_d    = acc_base;
        cnt_d    = cnt_q;
        if (i_pop) begin
            cnt_d = cnt_d - 7'(KYBER_WORD_W);
        end
        if (i_push) begin
            acc_d = acc_d | (KYBER_ACC_W'(packed_bits) << push_off);
            cnt_d = cnt_d + 7'(beat_bits);
        end
        if (i_clr) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    // Accumulator and bit-count registers.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_word = acc_q[KYBER_WORD_W-1:0];
    assign o_cnt  = cnt_q;

endmodule

// File: rtl/byte_encode.sv
// Kyber ByteEncode_l: packs 256 l-bit coefficients (4 per beat) into a
// 32*l-byte little-endian stream of 64-bit words, then pulses o_done.
module byte_encode
    import kyber_pkg::*;
#(
    parameter int N_COEFF = 256,
    parameter int COEFF_W = 12,
    parameter int LANES   = 4,
    parameter int WORD_W  = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [3:0]               i_l,
    input  logic [LANES*COEFF_W-1:0] i_coeffs,
    input  logic                     i_coeffs_valid,
    output logic                     o_coeffs_ready,
    output logic [WORD_W-1:0]        o_bytes,
    output logic                     o_bytes_valid,
    input  logic                     i_bytes_ready,
    output logic                     o_done
);

    localparam int BEATS = N_COEFF / LANES;

    encode_state_t state_q, state_d;
    logic [3:0]    l_q, l_d;
    logic [6:0]    in_cnt_q, in_cnt_d;
    logic [5:0]    out_cnt_q, out_cnt_d;

    logic [3:0]             l_eff;
    logic [KYBER_CNT_W-1:0] cnt;
    logic [WORD_W-1:0]      word;
    logic                   accept;
    logic                   pop;
    logic                   last_pop;
    logic                   clr;

    // In IDLE the first beat uses the live (clamped) i_l; afterwards the latched one.
    assign l_eff = (state_q == IDLE) ? clamp_l(i_l) : l_q;
    assign clr   = (state_q == DONE);

    assign o_coeffs_ready = !i_rst && (state_q != DONE)
                          && (in_cnt_q < 7'(BEATS)) && (cnt < 7'(WORD_W));
    assign o_bytes_valid  = !i_rst && (cnt >= 7'(WORD_W));
    assign o_bytes        = i_rst ? '0 : word;
    assign o_done         = !i_rst && (state_q == DONE);

    assign accept   = i_coeffs_valid && o_coeffs_ready;
    assign pop      = o_bytes_valid && i_bytes_ready;
    assign last_pop = pop && (out_cnt_q == (6'({l_q, 2'b00}) - 6'd1));

    bit_packer u_packer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (clr),
        .i_push   (accept),
        .i_pop    (pop),
        .i_l      (l_eff),
        .i_coeffs (i_coeffs),
        .o_word   (word),
        .o_cnt    (cnt)
    );

    // Polynomial sequencing: latch l on the first beat, count beats and words.
    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    l_d      = clamp_l(i_l);
                    in_cnt_d = 7'd1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + 7'd1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 6'd1;
                end
                if (last_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; a reset mid-polynomial drops everything without o_done.
    always_ff @(posedge i_clk) begin
        // NOTE: only control and datapath registers carry a reset here; there is
        // no memory array, so the whole state can be cleared in one cycle.
        if (i_rst) begin
            state_q   <= IDLE;
            l_q       <= 4'(KYBER_L_MAX);
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_byte_encode.sv
// Directed bench for byte_encode: drives whole polynomials, captures popped
// words and compares against a bitwise ByteEncode reference.
module tb_byte_encode;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_l;
    logic [47:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_coeffs_ready;
    logic [63:0] o_bytes;
    logic        o_bytes_valid;
    logic        i_bytes_ready;
    logic        o_done;

    int total;
    int bad;

    logic [11:0] coeff_mem [256];
    logic [63:0] words [$];
    int done_seen, done_cyc, last_pop_cyc, stable_err;
    int first_valid_cyc, second_acc_cyc;

    byte_encode dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_l            (i_l),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_bytes        (o_bytes),
        .o_bytes_valid  (o_bytes_valid),
        .i_bytes_ready  (i_bytes_ready),
        .o_done         (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: stream bit n = bit (n mod l) of coefficient n/l.
    function automatic logic [63:0] golden_word(input int k, input int l);
        logic [63:0] w;
        int n;
        for (int b = 0; b < 64; b++) begin
            n    = 64 * k + b;
            w[b] = coeff_mem[n / l][n % l];
        end
        return w;
    endfunction

    // Drive one polynomial, sampling and driving on the falling edge.
    task automatic run_poly(input logic [3:0] lin, input int rdy_pct,
                            input bit l_glitch, input int abort_at);
        int  beat, cyc;
        bit  hold;
        logic [63:0] held;
        words.delete();
        done_seen = 0; done_cyc = -1; last_pop_cyc = -1; stable_err = 0;
        first_valid_cyc = -1; second_acc_cyc = -1;
        beat = 0; cyc = 0; hold = 0; held = '0;
        while (cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
            if (o_done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (hold && o_bytes !== held) stable_err++;
            if (o_bytes_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done_seen > 0 && cyc >= done_cyc + 2) break;
            if (abort_at >= 0 && beat == abort_at) begin
                i_coeffs_valid = 1'b0;
                i_bytes_ready  = 1'b0;
                i_rst          = 1'b1;
                @(negedge i_clk);
                i_rst = 1'b0;
                repeat (3) begin
                    @(negedge i_clk);
                    if (o_done) done_seen++;
                end
                break;
            end
            i_l = (l_glitch && beat > 0) ? 4'd3 : lin;
            if (beat < 64) begin
                i_coeffs_valid = 1'b1;
                i_coeffs = {coeff_mem[4*beat+3], coeff_mem[4*beat+2],
                            coeff_mem[4*beat+1], coeff_mem[4*beat]};
            end else begin
                i_coeffs_valid = 1'b0;
            end
            i_bytes_ready = ($urandom_range(99) < rdy_pct);
            if (i_coeffs_valid && o_coeffs_ready) begin
                if (beat == 1) second_acc_cyc = cyc;
                beat++;
            end
            if (o_bytes_valid && i_bytes_ready) begin
                words.push_back(o_bytes);
                last_pop_cyc = cyc;
            end
            hold = o_bytes_valid && !i_bytes_ready;
            held = o_bytes;
        end
        i_coeffs_valid = 1'b0;
        i_bytes_ready  = 1'b0;
        if (abort_at < 0 && done_seen == 0)
            $display("FAIL timeout l_in=%0d got=no_done required=done", lin);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        total++; if (o_bytes_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_bytes_valid); end
        total++; if (o_coeffs_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", o_coeffs_ready); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", o_done); end
        total++; if (o_bytes !== 64'h0) begin bad++; $display("FAIL rst_bytes got=%h exp=0", o_bytes); end
        i_rst = 1'b0;
        @(negedge i_clk);
        total++; if (o_coeffs_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", o_coeffs_ready); end
    endtask

    task automatic test_l12();
        int err;
        for (int i = 0; i < 256; i++) coeff_mem[i] = 12'(i);
        run_poly(4'd12, 100, 1'b0, -1);
        total++; if (words.size() !== 48) begin bad++; $display("FAIL l12_count got=%0d exp=48", words.size()); end
        total++; if (words[0] !== 64'h5004_0030_0200_1000) begin bad++; $display("FAIL l12_word0 got=%h exp=5004003002001000", words[0]); end
        err = 0;
        for (int k = 0; k < 48; k++) if (words[k] !== golden_word(k, 12)) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL l12_words got=%0d_bad exp=0_bad", err); end
        total++; if (done_seen !== 1) begin bad++; $display("FAIL l12_done_count got=%0d exp=1", done_seen); end
        total++; if (done_cyc !== last_pop_cyc + 1) begin bad++; $display("FAIL l12_done_time got=%0d exp=%0d", done_cyc, last_pop_cyc + 1); end
        total++; if (first_valid_cyc !== second_acc_cyc + 1) begin bad++; $display("FAIL l12_latency got=%0d exp=%0d", first_valid_cyc, second_acc_cyc + 1); end
    endtask

    task automatic test_l1();
        int err;
        for (int i = 0; i < 256; i++) coeff_mem[i] = (i % 2 == 1) ? 12'hFFF : 12'hFFE;
        run_poly(4'd1, 100, 1'b0, -1);
        total++; if (words.size() !== 4) begin bad++; $display("FAIL l1_count got=%0d exp=4", words.size()); end
        err = 0;
        for (int k = 0; k < 4; k++) if (words[k] !== 64'hAAAA_AAAA_AAAA_AAAA) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL l1_words got=%0d_bad exp=0_bad", err); end
        total++; if (done_seen !== 1) begin bad++; $display("FAIL l1_done got=%0d exp=1", done_seen); end
    endtask

    task automatic test_l4_backpressure();
        int err;
        for (int i = 0; i < 256; i++) coeff_mem[i] = 12'($urandom);
        run_poly(4'd4, 30, 1'b0, -1);
        total++; if (words.size() !== 16) begin bad++; $display("FAIL l4_count got=%0d exp=16", words.size()); end
        err = 0;
        for (int k = 0; k < 16; k++) if (words[k] !== golden_word(k, 4)) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL l4_words got=%0d_bad exp=0_bad", err); end
        total++; if (stable_err !== 0) begin bad++; $display("FAIL l4_hold got=%0d_changes exp=0", stable_err); end
        total++; if (done_seen !== 1) begin bad++; $display("FAIL l4_done got=%0d exp=1", done_seen); end
    endtask

    task automatic test_l10_l11();
        int err, derr, n;
        logic [11:0] c, mask;
        for (int l = 10; l <= 11; l++) begin
            for (int i = 0; i < 256; i++) coeff_mem[i] = 12'($urandom);
            run_poly(4'(l), 70, 1'b0, -1);
            total++; if (words.size() !== 4 * l) begin bad++; $display("FAIL l%0d_count got=%0d exp=%0d", l, words.size(), 4 * l); end
            err = 0;
            for (int k = 0; k < 4 * l; k++) if (words[k] !== golden_word(k, l)) err++;
            total++; if (err !== 0) begin bad++; $display("FAIL l%0d_words got=%0d_bad exp=0_bad", l, err); end
            mask = 12'((13'd1 << l) - 13'd1);
            derr = 0;
            for (int i = 0; i < 256; i++) begin
                c = '0;
                for (int j = 0; j < l; j++) begin
                    n    = i * l + j;
                    c[j] = words[n / 64][n % 64];
                end
                if (c !== (coeff_mem[i] & mask)) derr++;
            end
            total++; if (derr !== 0) begin bad++; $display("FAIL l%0d_decode got=%0d_bad exp=0_bad", l, derr); end
            total++; if (done_seen !== 1) begin bad++; $display("FAIL l%0d_done got=%0d exp=1", l, done_seen); end
        end
    endtask

    task automatic test_reset_mid();
        int err;
        for (int i = 0; i < 256; i++) coeff_mem[i] = 12'($urandom);
        run_poly(4'd5, 100, 1'b0, 20);
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_seen); end
        for (int i = 0; i < 256; i++) coeff_mem[i] = 12'($urandom);
        run_poly(4'd5, 100, 1'b0, -1);
        total++; if (words.size() !== 20) begin bad++; $display("FAIL rstmid_count got=%0d exp=20", words.size()); end
        err = 0;
        for (int k = 0; k < 20; k++) if (words[k] !== golden_word(k, 5)) err++;
        total++; if (err !== 0) begin bad++; $display("FAIL rstmid_words got=%0d_bad exp=0_bad", err); end
        total++; if (done_seen !== 1) begin bad++; $display("FAIL rstmid_done got=%0d exp=1", done_seen); end
    endtask

    task automatic test_clamp();
        int err;
        logic [3:0] lins [2];
        lins[0] = 4'd0;
        lins[1] = 4'd15;
        for (int i = 0; i < 256; i++) coeff_mem[i] = 12'(i);
        for (int t = 0; t < 2; t++) begin
            // the second pass also wiggles i_l after the first beat
            run_poly(lins[t], 100, (t == 1), -1);
            total++; if (words.size() !== 48) begin bad++; $display("FAIL clamp%0d_count got=%0d exp=48", lins[t], words.size()); end
            total++; if (words[0] !== 64'h5004_0030_0200_1000) begin bad++; $display("FAIL clamp%0d_word0 got=%h exp=5004003002001000", lins[t], words[0]); end
            err = 0;
            for (int k = 0; k < 48; k++) if (words[k] !== golden_word(k, 12)) err++;
            total++; if (err !== 0) begin bad++; $display("FAIL clamp%0d_words got=%0d_bad exp=0_bad", lins[t], err); end
            total++; if (done_seen !== 1) begin bad++; $display("FAIL clamp%0d_done got=%0d exp=1", lins[t], done_seen); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b1;
        i_l = 4'd12;
        i_coeffs = '0;
        i_coeffs_valid = 1'b0;
        i_bytes_ready = 1'b0;
        test_reset();
        test_l12();
        test_l1();
        test_l4_backpressure();
        test_l10_l11();
        test_reset_mid();
        test_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
